// File: rtl/exon_bus_pkg.sv
// Shared constants, bus-source encoding and source priority encoder for exon_bus.
package exon_bus_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_IN,
        SRC_A,
        SRC_B,
        SRC_C
    } bus_src_e;

    // External input has highest priority, then A, B, C.
    function automatic bus_src_e bus_src_sel(input logic eni, input logic ena,
                                             input logic enb, input logic enc);
        if (eni) begin
            return SRC_IN;
        end else if (ena) begin
            return SRC_A;
        end else if (enb) begin
            return SRC_B;
        end else if (enc) begin
            return SRC_C;
        end
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/exon_bus_reg.sv
// Loadable WIDTH-bit register with asynchronous active-high clear.
module exon_bus_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;
    logic [Width-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/exon_bus.sv
// Three registers sharing one priority-muxed internal bus (zbus).
// Optional EXON_BUS_CONTENTION_EN adds bus_conflict and a saturating conflict_cnt.
module exon_bus
    import exon_bus_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             enb,
    input  logic             enc,
    input  logic             eni,
    input  logic             lda,
    input  logic             ldb,
    input  logic             ldc,
    input  logic [WIDTH-1:0] inData,
    output logic [WIDTH-1:0] rega,
    output logic [WIDTH-1:0] regb,
    output logic [WIDTH-1:0] regc,
`ifdef EXON_BUS_CONTENTION_EN
    output logic             bus_conflict,
    output logic [7:0]       conflict_cnt,
`endif
    output logic [WIDTH-1:0] zbus
);

    bus_src_e src;

    // rst_n is active-high: 1 clears the registers.
    exon_bus_reg #(.Width(WIDTH)) u_reg_a (
        .clk_i(clk),
        .rst_i(rst_n),
        .ld_i (lda),
        .d_i  (zbus),
        .q_o  (rega)
    );

    exon_bus_reg #(.Width(WIDTH)) u_reg_b (
        .clk_i(clk),
        .rst_i(rst_n),
        .ld_i (ldb),
        .d_i  (zbus),
        .q_o  (regb)
    );

    exon_bus_reg #(.Width(WIDTH)) u_reg_c (
        .clk_i(clk),
        .rst_i(rst_n),
        .ld_i (ldc),
        .d_i  (zbus),
        .q_o  (regc)
    );

    always_comb begin
        src  = bus_src_sel(eni, ena, enb, enc);
        zbus = '0;
        case (src)
            SRC_IN:  zbus = inData;
            SRC_A:   zbus = rega;
            SRC_B:   zbus = regb;
            SRC_C:   zbus = regc;
            default: zbus = '0;
        endcase
    end

`ifdef EXON_BUS_CONTENTION_EN
    logic [7:0] conflict_cnt_q;
    logic [7:0] conflict_cnt_d;

    assign bus_conflict = (eni & (ena | enb | enc)) | (ena & (enb | enc)) | (enb & enc);

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (bus_conflict && (conflict_cnt_q != 8'hFF)) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_exon_bus.sv
// Directed self-checking bench for exon_bus; contention checks build with EXON_BUS_CONTENTION_EN.
module tb_exon_bus;

    logic       clk;
    logic       rst_n;
    logic       ena, enb, enc, eni;
    logic       lda, ldb, ldc;
    logic [7:0] inData;
    logic [7:0] rega, regb, regc, zbus;
`ifdef EXON_BUS_CONTENTION_EN
    logic       bus_conflict;
    logic [7:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    exon_bus #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .enb   (enb),
        .enc   (enc),
        .eni   (eni),
        .lda   (lda),
        .ldb   (ldb),
        .ldc   (ldc),
        .inData(inData),
        .rega  (rega),
        .regb  (regb),
        .regc  (regc),
`ifdef EXON_BUS_CONTENTION_EN
        .bus_conflict(bus_conflict),
        .conflict_cnt(conflict_cnt),
`endif
        .zbus  (zbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so outputs have settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {ena, enb, enc, eni, lda, ldb, ldc} = '0;
        inData = 8'h00;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;

        // Preload nonzero contents, then assert reset between edges.
        rst_n  = 1'b0;
        eni    = 1'b1;
        inData = 8'hC7;
        {lda, ldb, ldc} = 3'b111;
        #1;
        chk("zbus_preload", zbus, 8'hC7);
        step();
        chk("rega_preload", rega, 8'hC7);
        chk("regb_preload", regb, 8'hC7);
        chk("regc_preload", regc, 8'hC7);
        idle_inputs();
        #1;
        rst_n = 1'b1;
        #1;
        chk("rega_async_rst", rega, 8'h00);
        chk("regb_async_rst", regb, 8'h00);
        chk("regc_async_rst", regc, 8'h00);
        chk("zbus_rst_idle", zbus, 8'h00);
        eni    = 1'b1;
        inData = 8'h99;
        #1;
        chk("zbus_rst_eni", zbus, 8'h99);
        idle_inputs();
        step();
        #2;
        rst_n = 1'b0;

        // Input to A.
        eni    = 1'b1;
        inData = 8'hAA;
        #1;
        chk("zbus_in_aa", zbus, 8'hAA);
        lda = 1'b1;
        step();
        chk("rega_load_aa", rega, 8'hAA);
        chk("regb_untouched", regb, 8'h00);
        chk("regc_untouched", regc, 8'h00);
        lda = 1'b0;
        eni = 1'b0;
        #1;
        chk("zbus_idle", zbus, 8'h00);
        step();
        chk("rega_hold", rega, 8'hAA);

        // A broadcast to B and C.
        ena = 1'b1;
        ldb = 1'b1;
        ldc = 1'b1;
        #1;
        chk("zbus_from_a", zbus, 8'hAA);
        step();
        chk("regb_bcast", regb, 8'hAA);
        chk("regc_bcast", regc, 8'hAA);
        idle_inputs();
        enb    = 1'b1;
        inData = 8'h55;
        eni    = 1'b1;
        #1;
        chk("zbus_eni_over_enb", zbus, 8'h55);
        eni = 1'b0;
        #1;
        chk("zbus_from_b", zbus, 8'hAA);

        // Give C a distinct value to check lower priorities.
        idle_inputs();
        step();
        eni    = 1'b1;
        inData = 8'h5A;
        ldc    = 1'b1;
        step();
        chk("regc_load_5a", regc, 8'h5A);
        idle_inputs();
        enc = 1'b1;
        #1;
        chk("zbus_from_c", zbus, 8'h5A);
        ena = 1'b1;
        #1;
        chk("zbus_ena_over_enc", zbus, 8'hAA);
        ena = 1'b0;
        enb = 1'b1;
        #1;
        chk("zbus_enb_over_enc", zbus, 8'hAA);
        idle_inputs();
        step();

        // Self-load and idle load.
        ena = 1'b1;
        lda = 1'b1;
        step();
        chk("rega_self_load", rega, 8'hAA);
        idle_inputs();
        ldb = 1'b1;
        step();
        chk("regb_idle_load", regb, 8'h00);
        chk("regc_kept", regc, 8'h5A);
        idle_inputs();
        step();

        // Reset pulse between edges while a load is pending.
        eni    = 1'b1;
        inData = 8'h3C;
        lda    = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rega_midload_rst", rega, 8'h00);
        step();
        chk("rega_rst_held_1", rega, 8'h00);
        step();
        chk("rega_rst_held_2", rega, 8'h00);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        step();
        chk("rega_after_rst", rega, 8'h00);

`ifdef EXON_BUS_CONTENTION_EN
        chk("cnt_start", conflict_cnt, 8'd0);
        eni    = 1'b1;
        #1;
        chk("no_conflict_single", {7'd0, bus_conflict}, 8'd1 - 8'd1);
        ena    = 1'b1;
        inData = 8'h81;
        #1;
        chk("conflict_flag", {7'd0, bus_conflict}, 8'd1);
        chk("zbus_conflict", zbus, 8'h81);
        repeat (3) step();
        chk("cnt_three", conflict_cnt, 8'd3);
        repeat (300) step();
        chk("cnt_saturate", conflict_cnt, 8'd255);
        idle_inputs();
        #1;
        rst_n = 1'b1;
        #1;
        chk("cnt_rst_clear", conflict_cnt, 8'd0);
        rst_n = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exon_bus.md
Name: exon_bus

Overview:
- Three-register datapath sharing one internal data bus (zbus).
- Each source (external input, reg A, reg B, reg C) drives zbus when its enable is high.
- Each register captures zbus on the rising clock edge when its load strobe is high.
- Used as a bus-transfer building block inside the SoC datapath; zbus and all register contents are visible at the ports.

Parameters:
- WIDTH, 8, bit width of inData, zbus and each register.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous reset, active-high despite the name: 1 = reset asserted.
- ena  input  1  drive rega onto zbus.
- enb  input  1  drive regb onto zbus.
- enc  input  1  drive regc onto zbus.
- eni  input  1  drive inData onto zbus.
- lda  input  1  load zbus into reg A.
- ldb  input  1  load zbus into reg B.
- ldc  input  1  load zbus into reg C.
- inData  input  WIDTH  external data source.
- rega  output  WIDTH  current contents of reg A.
- regb  output  WIDTH  current contents of reg B.
- regc  output  WIDTH  current contents of reg C.
- zbus  output  WIDTH  current internal bus value.

Behaviour:
- Reset: while rst_n=1, rega, regb and regc are forced to 0 immediately, without waiting for a clock edge. Reset has priority over loads. Reset asserted mid-transfer discards the pending load.
- zbus is combinational, driven by a priority mux (no internal tri-states):
  - eni → inData
  - else ena → rega
  - else enb → regb
  - else enc → regc
  - else 0 (idle bus reads all-zeros)
- zbus follows enables and inData in the same cycle; zbus reads 0 during reset unless eni=1.
- Load timing:
  - On a rising clk edge with rst_n=0, each register whose ld strobe is 1 captures the zbus value present just before the edge.
  - Registers whose strobe is 0 hold their value.
  - Load latency is 1 edge; the new value is visible on regX and zbus after that edge.
- Simultaneous loads: multiple ld strobes high at once all capture the same zbus value (broadcast).
- Self-load: with enX=1 and ldX=1 for the same register, the register reloads its own value (net hold); no combinational loop through the register.
- Load with no enable: the register captures 0.
- Enables and loads are level-sensitive per edge; no handshake and no FSM.

Optional Feature:
- Macro: EXON_BUS_CONTENTION_EN.
- When defined:
  - Extra output bus_conflict (1 bit), combinationally 1 whenever two or more of eni/ena/enb/enc are high in the same cycle.
  - Extra output conflict_cnt (8 bits): counts rising edges (with rst_n=0) on which bus_conflict=1, saturates at 255, and is cleared by reset.
  - Mux priority is unchanged.
- When undefined: neither port exists; the behaviour is otherwise identical.

Decomposition:
- Package exon_bus_pkg:
  - WIDTH default constant.
  - Bus-source select enum {SRC_NONE, SRC_IN, SRC_A, SRC_B, SRC_C}.
  - Priority-encode function from enables to that enum.
- One natural sub-module, exon_bus_reg: a WIDTH-bit register with async active-high reset and load enable, instantiated three times.
- Bus mux and optional contention logic stay in the top level.

Test Plan:
- Reset: assert rst_n=1 with random register contents → rega=regb=regc=0 immediately, without waiting for a clock edge; zbus=0 with all enables low.
- Input-to-A transfer: release reset, inData=8'hAA, eni=1 → zbus=8'hAA the same cycle; lda=1 for one edge → rega=8'hAA, regb=regc=0; then drop lda and eni → zbus=0, rega holds 8'hAA.
- Register-to-register: rega=8'hAA, ena=1, ldb=1 and ldc=1 for one edge → regb=regc=8'hAA; then enb=1, inData=8'h55, eni=1 → zbus=8'h55 (eni wins priority).
- Self-load and idle load:
  - ena=1, lda=1 → rega stays 8'hAA.
  - All enables low, ldb=1 → regb=0.
- Async reset mid-load: eni=1, inData=8'h3C, lda=1, and rst_n pulses 1 between clock edges → rega=0 immediately and stays 0 while reset is held.
- With EXON_BUS_CONTENTION_EN: eni=ena=1 for 3 edges → bus_conflict=1, conflict_cnt=3, zbus=inData; hold conflict for 300 edges → conflict_cnt=255.
